rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_pkg.sv | 12 +
 rtl/grant_decoder_2_4.sv | 20 ++
 rtl/rr_arbiter_4.sv | 139 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared encodings and constants for the 4-way round-robin arbiter
package rr_arbiter_pkg;

    localparam int NUM_REQ                = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/grant_decoder_2_4.sv
// rtl/grant_decoder_2_4.sv - 2-bit owner index to 4-bit one-hot grant decode
//
// Ports:
//   idx_i    - binary index of the current owner
//   en_i     - high while an owner exists; low forces an all-zero output
//   onehot_o - one-hot grant vector (00->0001, 01->0010, 10->0100, 11->1000)
module grant_decoder_2_4 (
    input  logic [1:0] idx_i,
    input  logic       en_i,
    output logic [3:0] onehot_o
);

    always_comb begin
        onehot_o = 4'b0000;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-requester round-robin arbiter with optional grant-hold timeout
//
// Build option: define RR_ARBITER_TIMEOUT_EN to bound grant hold to
// TIMEOUT_CYCLES cycles; undefined builds have unbounded hold and timeout = 0.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst_n       - asynchronous active-low reset
//   req         - per-requester request, bit i = requester i
//   done        - release strobe from the current owner, only looked at while granting
//   grant       - one-hot grant, all-zero when nobody owns the resource
//   grant_idx   - binary index of the owner, 0 when nobody owns the resource
//   grant_valid - high exactly when grant is non-zero
//   timeout     - one-cycle pulse, coincident with grant clearing, on forced revocation
module rr_arbiter_4
    import rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter_4: TIMEOUT_CYCLES must lie in 2..255");
    end

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] pick;
    logic       release_req;
    logic       limit_hit;

    // Round-robin search: walking offsets downwards lets the smallest offset
    // from ptr win, and the 2-bit add wraps 3->0 for free.
    always_comb begin
        pick = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                pick = ptr_q + 2'(i);
            end
        end
    end

    assign release_req = done || !req[idx_q];

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign limit_hit = (cnt_q == CNT_LIMIT);

    // The counter sits at zero through IDLE so it starts cleared on entry.
    // A normal release on the limit cycle wins, so no pulse in that case.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = 8'd0;
        end else if (!release_req && limit_hit) begin
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // grant_idx is zeroed on exit so it reads 0 whenever there is no owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = pick;
                end
            end
            GRANT: begin
                if (release_req || limit_hit) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 2'd1;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = idx_q;

    grant_decoder_2_4 u_decoder (
        .idx_i    (idx_q),
        .en_i     (grant_valid),
        .onehot_o (grant)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - randomized self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

    localparam int TCYC = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // reference model state
    int owner;      // -1 = nobody
    int mptr;
    int held;       // grant cycles completed by current owner
    bit mto;

    logic [3:0] prev_grant;
    int         order_q[$];

    rr_arbiter_4 #(.TIMEOUT_CYCLES(TCYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        mptr  = 0;
        held  = 0;
        mto   = 1'b0;
    endtask

    task automatic model_update();
        mto = 1'b0;
        if (owner < 0) begin
            if (req != 4'd0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (req[(mptr + k) % 4]) owner = (mptr + k) % 4;
                end
                held = 0;
            end
        end else begin
            held++;
            if (done || !req[owner]) begin
                mptr  = (owner + 1) % 4;
                owner = -1;
            end else if (TO_EN && held == TCYC) begin
                mptr  = (owner + 1) % 4;
                owner = -1;
                mto   = 1'b1;
            end
        end
    endtask

    task automatic compare();
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        ei = (owner >= 0) ? 2'(owner) : 2'd0;
        check("grant", 32'(grant), 32'(eg));
        check("grant_idx", 32'(grant_idx), 32'(ei));
        check("grant_valid", 32'(grant_valid), 32'(owner >= 0));
        check("timeout", 32'(timeout), 32'(mto));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        @(negedge clk);
        compare();
        if (grant != 4'd0 && prev_grant == 4'd0) order_q.push_back(int'(grant));
        prev_grant = grant;
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{1, 2, 4, 8, 1};
        prev_grant = 4'd0;
        rst_n = 1'b0;
        req   = 4'd0;
        done  = 1'b0;
        model_reset();
        step();
        step();

        // round-robin order with everybody requesting, one-cycle release each grant
        rst_n = 1'b1;
        req   = 4'b1111;
        order_q.delete();
        for (int c = 0; c < 10; c++) begin
            done = (owner >= 0);
            step();
        end
        done = 1'b0;
        check("order_len", 32'(order_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < order_q.size(); k++) begin
            check("order", 32'(order_q[k]), 32'(exp_order[k]));
        end

        // owner 2 held while other requests toggle
        req = 4'b0000;
        step();
        step();
        req = 4'b0100;
        step();
        for (int c = 0; c < 10; c++) begin
            req = {1'b0, 1'b1, 2'($urandom_range(0, 3))} | {$urandom_range(0, 1) == 1, 3'b000};
            step();
        end

        // owner drops its request without done
        req = 4'b1000;
        done = 1'b0;
        step();
        step();
        req = 4'b0011;
        step();
        step();
        step();

        // never-releasing owner 0, then requester 1 also pending
        req = 4'b0000;
        step();
        step();
        req = 4'b0001;
        for (int c = 0; c < 100; c++) step();
        req = 4'b0011;
        for (int c = 0; c < 12; c++) step();

        // randomized traffic, requests change slowly so holds occur
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            done = ($urandom_range(0, 5) == 0);
            step();
        end

        // asynchronous reset in the middle of a grant to requester 2
        done = 1'b0;
        req  = 4'b0000;
        step();
        step();
        req = 4'b0100;
        step();
        step();
        check("pre_reset_grant", 32'(grant), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_grant", 32'(grant), 32'h0);
        check("async_valid", 32'(grant_valid), 32'h0);
        check("async_timeout", 32'(timeout), 32'h0);
        step();
        rst_n = 1'b1;
        req   = 4'b1100;
        step();
        check("post_reset_grant", 32'(grant), 32'h4);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
